// File: rtl/reg_write_arbiter_if.sv
// Bus between the requesters and the write arbiter: per-requester
// request/data lines in, one-hot grant and the register write port out.
interface reg_write_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) ();
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  reg_enable;
    logic [WIDTH-1:0]      reg_data;
    logic                  busy;
    logic [IDW-1:0]        last_id;

    // Requester side: raises requests, watches grants and the write port
    modport master (
        output req, req_data,
        input  gnt, reg_enable, reg_data, busy, last_id
    );

    // Arbiter side
    modport slave (
        input  req, req_data,
        output gnt, reg_enable, reg_data, busy, last_id
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter in front of a single register write port.
// IDLE picks the first requester at or above the rotating pointer and
// issues a one-cycle write; WRITE is a mandatory one-cycle gap, so the
// port carries at most one write every two cycles.
module reg_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_,
    reg_write_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [IDW-1:0]   ptr_r, ptr_nxt_s;
    logic [IDW-1:0]   last_id_r, last_id_nxt_s;
    logic [NREQ-1:0]  gnt_r, gnt_nxt_s;
    logic             en_r, en_nxt_s;
    logic [WIDTH-1:0] data_r, data_nxt_s;

    logic             found_s;
    logic [IDW-1:0]   win_s;
    logic [IDW-1:0]   idx_s;
    logic [WIDTH-1:0] win_data_s;

    // Round-robin search: first set request at or above ptr, wrapping at NREQ
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = IDW'((int'(ptr_r) + k) % NREQ);
            if (!found_s && bus.req[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Only the winner's data slice is looked at; other slices may be junk
    always_comb begin
        win_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_s == IDW'(i)) begin
                win_data_s = bus.req_data[i*WIDTH +: WIDTH];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Next state and next registered outputs; write port idles at zero
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        last_id_nxt_s = last_id_r;
        gnt_nxt_s     = '0;
        en_nxt_s      = 1'b0;
        data_nxt_s    = '0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    gnt_nxt_s     = NREQ'(1'b1) << win_s;
                    en_nxt_s      = 1'b1;
                    data_nxt_s    = win_data_s;
                    last_id_nxt_s = win_s;
                    // explicit wrap so non-power-of-2 NREQ stays in range
                    ptr_nxt_s     = (win_s == IDW'(NREQ - 1)) ? '0 : win_s + IDW'(1);
                    state_nxt_s   = WRITE;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            WRITE: begin
                // requests are ignored here; a still-high req is a new one next IDLE
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any grant in flight
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            last_id_r <= '0;
            gnt_r     <= '0;
            en_r      <= 1'b0;
            data_r    <= '0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            last_id_r <= last_id_nxt_s;
            gnt_r     <= gnt_nxt_s;
            en_r      <= en_nxt_s;
            data_r    <= data_nxt_s;
        end
    end

    assign bus.gnt        = gnt_r;
    assign bus.reg_enable = en_r;
    assign bus.reg_data   = data_r;
    assign bus.last_id    = last_id_r;
    assign bus.busy       = (state_r == WRITE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios followed by random
// requesters, all checked against a queue-free behavioural model of the
// round-robin rules plus a stand-in for the downstream register.
module tb_reg_write_arbiter;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int MAXW  = 2 * (NREQ - 1);

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    reg_write_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

    reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    // Downstream register the arbiter feeds
    logic [WIDTH-1:0] reg_out;
    always_ff @(posedge clk) begin
        if (!rst_)               reg_out <= '0;
        else if (bus.reg_enable) reg_out <= bus.reg_data;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int               m_ptr;
    bit               m_write;
    logic [NREQ-1:0]  e_gnt;
    bit               e_en;
    logic [WIDTH-1:0] e_data;
    int               e_last;
    logic [WIDTH-1:0] m_reg;
    int               g_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic model_edge(input logic rn, input logic [NREQ-1:0] r,
                              input logic [NREQ*WIDTH-1:0] d);
        int w;
        if (!rn) begin
            m_reg = '0; m_ptr = 0; m_write = 0;
            e_gnt = '0; e_en = 0; e_data = '0; e_last = 0;
        end else begin
            if (e_en) m_reg = e_data;
            w = m_write ? -1 : rr_pick(r, m_ptr);
            m_write = 0; e_gnt = '0; e_en = 0; e_data = '0;
            if (w >= 0) begin
                e_gnt   = NREQ'(1) << w;
                e_en    = 1;
                e_data  = WIDTH'(d >> (w * WIDTH));
                e_last  = w;
                m_ptr   = (w + 1) % NREQ;
                m_write = 1;
            end
        end
    endtask

    // One clock: drive away from the edge, update model at the edge, check after
    task automatic cycle(input logic rn, input logic [NREQ-1:0] r,
                         input logic [NREQ*WIDTH-1:0] d);
        rst_ = rn; bus.req = r; bus.req_data = d;
        @(posedge clk);
        model_edge(rn, r, d);
        #1;
        chk("gnt",        bus.gnt,        e_gnt);
        chk("reg_enable", bus.reg_enable, e_en);
        chk("reg_data",   bus.reg_data,   e_data);
        chk("busy",       bus.busy,       m_write);
        chk("last_id",    bus.last_id,    e_last);
        chk("reg_out",    reg_out,        m_reg);
        if (bus.gnt != '0) g_log.push_back(int'(bus.last_id));
    endtask

    logic [NREQ-1:0]       pend;
    logic [NREQ*WIDTH-1:0] dat;
    logic [WIDTH-1:0]      slot[NREQ];
    int                    waitc[NREQ];

    initial begin
        m_ptr = 0; m_write = 0; e_gnt = '0; e_en = 0; e_data = '0; e_last = 0; m_reg = '0;
        rst_ = 1'b0; bus.req = '0; bus.req_data = '0;

        // Reset with pending requests, then first grant goes to 0
        cycle(1'b0, 4'b1111, 32'h44332211);
        cycle(1'b0, 4'b1111, 32'h44332211);
        cycle(1'b1, 4'b1111, 32'h44332211);
        chk("rst_first_gnt", bus.gnt, 32'h1);
        cycle(1'b1, 4'b0000, 32'h0);

        // Single request, then a second requester
        cycle(1'b1, 4'b0001, 32'h000000AA);
        chk("single_data", bus.reg_data, 32'hAA);
        cycle(1'b1, 4'b0000, 32'h0);
        chk("single_out", reg_out, 32'hAA);
        cycle(1'b1, 4'b0100, 32'h00550000);
        cycle(1'b1, 4'b0000, 32'h0);
        chk("second_out", reg_out, 32'h55);

        // All four requesting, each drops after its grant
        cycle(1'b0, 4'b0000, 32'h0);
        g_log.delete();
        pend = 4'b1111;
        for (int c = 0; c < 9; c++) begin
            cycle(1'b1, pend, 32'h44332211);
            pend = pend & ~bus.gnt;
        end
        chk("all4_n", g_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < g_log.size(); i++) chk("all4_order", g_log[i], i);
        chk("all4_out", reg_out, 32'h44);

        // Fairness: req0/req2 re-asserted after every grant
        cycle(1'b0, 4'b0000, 32'h0);
        g_log.delete();
        pend = 4'b0101;
        for (int c = 0; c < 16; c++) begin
            cycle(1'b1, pend, 32'h00CC00AA);
            pend = 4'b0101 & ~bus.gnt;
        end
        chk("fair_n", g_log.size(), 32'd8);
        for (int i = 0; i < g_log.size(); i++) chk("fair_order", g_log[i], (i % 2) * 2);

        // Wrap-around: after grant to 3, 1001 goes to 0
        cycle(1'b1, 4'b1000, 32'h77000000);
        chk("wrap_g3", bus.last_id, 32'd3);
        cycle(1'b1, 4'b0000, 32'h0);
        cycle(1'b1, 4'b1001, 32'h770000EE);
        chk("wrap_gnt", bus.gnt, 32'h1);
        chk("wrap_last", bus.last_id, 32'd0);
        cycle(1'b1, 4'b0000, 32'h0);

        // Reset in the middle of a WRITE to requester 1
        cycle(1'b1, 4'b0010, 32'h00003300);
        chk("mid_gnt", bus.gnt, 32'h2);
        cycle(1'b0, 4'b0000, 32'h0);
        chk("mid_rst_en", bus.reg_enable, 32'h0);
        cycle(1'b1, 4'b1100, 32'h99880000);
        chk("mid_after_last", bus.last_id, 32'd2);
        cycle(1'b1, 4'b0000, 32'h0);

        // Random requesters with bounded-wait check
        pend = '0;
        for (int i = 0; i < NREQ; i++) begin waitc[i] = 0; slot[i] = '0; end
        for (int c = 0; c < 600; c++) begin
            logic rn;
            bit   was_idle;
            logic [NREQ-1:0] smp;
            rn = ($urandom_range(0, 79) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    slot[i] = WIDTH'($urandom);
                end
                dat[i*WIDTH +: WIDTH] = pend[i] ? slot[i] : WIDTH'($urandom);
            end
            was_idle = !m_write;
            smp = pend;
            cycle(rn, smp, dat);
            for (int i = 0; i < NREQ; i++) begin
                if (!rn) begin
                    waitc[i] = 0;
                end else if (smp[i] && e_gnt[i]) begin
                    if (waitc[i] > MAXW) chk("rr_wait", waitc[i], MAXW);
                    waitc[i] = 0;
                end else if (smp[i] && (waitc[i] > 0 || was_idle)) begin
                    waitc[i]++;
                end
            end
            pend = pend & ~e_gnt;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter sharing one `register` write port among NREQ requesters. Each requester holds a request with its data word. The arbiter grants one requester at a time and drives the register's `enable`/`data` inputs for exactly one cycle per grant. It sits directly in front of a `register` instance, and both blocks share the same `clk` and `rst_`.

## Interface
- `WIDTH`, 8: data word width; matches the downstream register.
- `NREQ`, 4: number of requesters, ≥2.
- `IDW`, `$clog2(NREQ)`: requester index width (derived).

- `clk`  in  1  single clock; everything on the rising edge.
- `rst_`  in  1  reset; synchronous and active-low.
- `req`  in  NREQ  per-requester write request; level, held until granted.
- `req_data`  in  NREQ*WIDTH  requester i's data in bits `[i*WIDTH +: WIDTH]`; stable while `req[i]`=1.
- `gnt`  out  NREQ  one-hot grant, registered, high for one cycle.
- `reg_enable`  out  1  to the register's `enable`, registered.
- `reg_data`  out  WIDTH  to the register's `data`, registered.
- `busy`  out  1  high while in WRITE.
- `last_id`  out  IDW  index of the most recent grant.

## Operation
- Two-state FSM: IDLE, WRITE.
- IDLE:
  - If `req` != 0, select a winner by round-robin: the first set bit of `req` searching upward from `ptr`, wrapping NREQ-1 → 0.
  - At the edge: `gnt` <= onehot(winner), `reg_enable` <= 1, `reg_data` <= winner's data, `last_id` <= winner, `ptr` <= (winner+1) mod NREQ, state <= WRITE.
  - If `req` == 0: stay in IDLE; `gnt`, `reg_enable` and `reg_data` stay 0.
- WRITE:
  - Lasts exactly one cycle. `req` is not evaluated.
  - At the edge: `gnt` <= 0, `reg_enable` <= 0, `reg_data` <= 0, state <= IDLE.
- Requester rule: on seeing `gnt[i]`=1, drop `req[i]` by the edge that ends WRITE. A `req[i]` still high in the following IDLE cycle is treated as a new request.
- `ptr` is internal, IDW bits, reset to 0. It wraps mod NREQ, so a non-power-of-2 NREQ must wrap explicitly.
- Only the winner's `req_data` slice is sampled. Non-requesting slices may be X without affecting outputs.
- `reg_data` is 0 whenever `reg_enable`=0.
- `busy` = (state == WRITE).
- Reset (`rst_`=0 at an edge, in any state including mid-WRITE):
  - state=IDLE, `ptr`=0, `gnt`=0, `reg_enable`=0, `reg_data`=0, `last_id`=0, `busy`=0.
  - Any grant in progress is dropped. Reset wins over every other event on the same edge.

## Timing
- A request sampled at edge E (IDLE) produces `gnt`, `reg_enable` and `reg_data` valid from E to E+1.
- The register captures at E+1, so register `out` shows the new value after E+1. Request → register `out` is 2 edges.
- Maximum throughput is one write per 2 cycles. With continuous requests, `reg_enable` toggles 1,0,1,0.
- Worst-case wait for a continuously requesting input: 2*(NREQ-1) cycles before its grant cycle.
- Simultaneous requests at one edge: exactly one grant. The others wait and are not lost.
- `req` rising during WRITE: picked up at the next IDLE edge.

## Test plan
- **Reset with pending requests:** `rst_`=0 for 2 cycles with `req`=4'b1111 → `gnt`=0, `reg_enable`=0, `reg_data`=8'h00, `busy`=0 throughout. After release, the first grant is `gnt`=4'b0001.
- **Single request:** `req`=4'b0001, data0=8'hAA.
  - Next cycle: `gnt`=4'b0001, `reg_enable`=1, `reg_data`=8'hAA, `last_id`=0.
  - Cycle after: all three are 0, and register `out`=8'hAA.
  - Then `req`=4'b0100, data2=8'h55 → register `out`=8'h55 two edges later.
- **All four requesting:** `req`=4'b1111, data = 11/22/33/44, each requester dropping after its grant → grants in order 0,1,2,3 on alternate cycles. `reg_data` sequence is 11,22,33,44; register `out` ends at 8'h44.
- **Fairness:** `req0` and `req2` re-asserted immediately after every grant for 8 grants → grant order 0,2,0,2,0,2,0,2; `req1` never granted.
- **Wrap-around:** after a grant to requester 3, apply `req`=4'b1001 → grant to 0 (not 3); `last_id`=0.
- **Reset mid-WRITE:** assert `rst_`=0 in the cycle where `gnt`=4'b0010 → all outputs 0 after the edge and `ptr`=0. Then `req`=4'b1100 → grant to 2.
